// File: rtl/act_requant_packer_if.sv
// ---------------------------------------------------------------------------
// act_requant_packer_if : beat input / vector output handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface act_requant_packer_if #(
  parameter int BUS_NUM = 8,
  parameter int LANES   = 2,
  parameter int IN_W    = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*IN_W-1:0]   in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [BUS_NUM*8-1:0]    out_vec;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

`default_nettype wire

// File: rtl/act_requant_packer.sv
// ---------------------------------------------------------------------------
// act_requant_packer : requantize accumulator lanes to int8 and pack vectors
// Optional saturation counter: REQUANT_SAT_CNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module act_requant_packer #(
  parameter int BUS_NUM = 8,
  parameter int LANES   = 2,
  parameter int IN_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  act_requant_packer_if.slave  bus,
  input  logic [7:0]           cfg_scale,
  input  logic [4:0]           cfg_shift
`ifdef REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]          sat_cnt
`endif
);

  localparam int BEATS = BUS_NUM / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = IN_W + 10;
  localparam logic signed [PW-1:0] C_MAX = PW'(127);
  localparam logic signed [PW-1:0] C_MIN = ~PW'(127);

  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [BUS_NUM*8-1:0]   pack_buf_q, pack_buf_d;
  logic [BUS_NUM*8-1:0]   out_vec_q, out_vec_d;
  logic                   out_valid_q, out_valid_d;
  logic [BUS_NUM*8-1:0]   merged;
  logic [LANES*8-1:0]     beat_res;
  logic                   completing;
  logic                   in_ready_w;
  logic                   accept;
`ifdef REQUANT_SAT_CNT_EN
  logic [LANES-1:0]       lane_sat;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [IN_W-1:0] lane;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   bias;
    logic signed [PW-1:0]   rnd;

    assign lane = bus.in_data[k*IN_W +: IN_W];
    assign prod = PW'(lane) * PW'($signed({1'b0, cfg_scale}));
    // Half-LSB bias before the arithmetic shift rounds half toward +inf.
    assign bias = (cfg_shift == 5'd0) ? '0 : (PW'(1) << (cfg_shift - 5'd1));
    assign rnd  = (prod + bias) >>> cfg_shift;

    assign beat_res[k*8 +: 8] = (rnd > C_MAX) ? 8'h7F :
                                (rnd < C_MIN) ? 8'h80 : rnd[7:0];
`ifdef REQUANT_SAT_CNT_EN
    assign lane_sat[k] = (rnd > C_MAX) || (rnd < C_MIN);
`endif
  end

  assign completing    = (beat_cnt_q == CNT_W'(BEATS - 1)) || bus.in_last;
  assign in_ready_w    = !(completing && out_valid_q && !bus.out_ready);
  assign accept        = bus.in_valid && in_ready_w;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;

  // pack_buf is zero above the current slot, so lanes past a partial vector stay 0.
  always_comb begin
    merged = pack_buf_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt_q == CNT_W'(b)) begin
        merged[b*LANES*8 +: LANES*8] = beat_res;
      end
    end
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pack_buf_d  = pack_buf_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (completing) begin
        out_vec_d   = merged;
        out_valid_d = 1'b1;
        beat_cnt_d  = '0;
        pack_buf_d  = '0;
      end else begin
        pack_buf_d  = merged;
        beat_cnt_d  = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      pack_buf_q  <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      pack_buf_q  <= pack_buf_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [16:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_cnt_q};
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        sat_sum = sat_sum + 17'(lane_sat[k]);
      end
    end
    sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

`default_nettype wire
